// File: rtl/rf_pkg.sv
// Shared constants and types for the RegFile write-back path.
package rf_pkg;

  localparam int W        = 8;
  localparam int A        = 4;
  localparam int LD_DEPTH = 4;
  localparam int IMM_REG  = 3;

  typedef enum logic [1:0] {SRC_NONE, SRC_MEM, SRC_IMM, SRC_ALU} wb_src_t;

  localparam logic [3:0] kLOD = 4'h1;
  localparam logic [3:0] kCPP = 4'h2;
  localparam logic [3:0] kCYY = 4'h3;

endpackage

// File: rtl/rf_ld_queue.sv
// In-order queue of outstanding load destinations with parallel address matching
// against every live entry (two read ports, one write destination, the immediate register).
module rf_ld_queue #(
  parameter int A       = 4,
  parameter int DEPTH   = 4,
  parameter int IMM_REG = 3,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic [A-1:0] push_addr,
  input  logic         pop,
  output logic [A-1:0] head,
  output logic         full,
  output logic         empty,
  input  logic [A-1:0] cmp_a,
  input  logic [A-1:0] cmp_b,
  input  logic [A-1:0] cmp_w,
  output logic         match_a,
  output logic         match_b,
  output logic         match_w,
  output logic         match_imm
);

  logic [A-1:0]  entry [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) entry[wr_ptr] <= push_addr;
  end

  assign head  = entry[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    logic          live;
    match_a   = 1'b0;
    match_b   = 1'b0;
    match_w   = 1'b0;
    match_imm = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off  = PW'(i) - rd_ptr;
      live = ({1'b0, off} < count);
      if (live && entry[i] == cmp_a)        match_a   = 1'b1;
      if (live && entry[i] == cmp_b)        match_b   = 1'b1;
      if (live && entry[i] == cmp_w)        match_w   = 1'b1;
      if (live && entry[i] == A'(IMM_REG))  match_imm = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// RegFile write-port arbiter: load returns, immediates (to IMM_REG) and ALU results.
// Define RF_WB_RR_EN to share the slot below load returns round-robin between immediate and ALU.
module rf_wb_ctrl #(
  parameter int W        = rf_pkg::W,
  parameter int A        = rf_pkg::A,
  parameter int LD_DEPTH = rf_pkg::LD_DEPTH,
  parameter int IMM_REG  = rf_pkg::IMM_REG
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         alu_valid,
  input  logic [A-1:0] alu_waddr,
  input  logic [W-1:0] alu_data,
  output logic         alu_ready,
  input  logic         imm_valid,
  input  logic [W-1:0] imm_data,
  output logic         imm_ready,
  input  logic         ld_issue_valid,
  input  logic [A-1:0] ld_waddr,
  output logic         ld_issue_ready,
  input  logic         mem_rvalid,
  input  logic [W-1:0] mem_rdata,
  input  logic [A-1:0] rd_addr_a,
  input  logic [A-1:0] rd_addr_b,
  output logic         hazard,
  output logic         rf_we,
  output logic [A-1:0] rf_waddr,
  output logic [W-1:0] rf_wdata,
  output logic         ld_err
);

  import rf_pkg::*;

  logic         ld_full, ld_empty, ld_push;
  logic [A-1:0] ld_head;
  logic         q_match_a, q_match_b, q_match_w, q_match_imm;
  logic         mem_win, imm_elig, alu_elig, imm_grant, alu_grant;
  wb_src_t      src_p0, src_p1;
  logic [A-1:0] waddr_p0;
  logic [W-1:0] wdata_p0;

  assign ld_issue_ready = !ld_full;
  assign ld_push        = ld_issue_valid && !ld_full;
  assign mem_win        = mem_rvalid && !ld_empty;

  rf_ld_queue #(.A(A), .DEPTH(LD_DEPTH), .IMM_REG(IMM_REG)) u_ld_queue (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (ld_push),
    .push_addr (ld_waddr),
    .pop       (mem_win),
    .head      (ld_head),
    .full      (ld_full),
    .empty     (ld_empty),
    .cmp_a     (rd_addr_a),
    .cmp_b     (rd_addr_b),
    .cmp_w     (alu_waddr),
    .match_a   (q_match_a),
    .match_b   (q_match_b),
    .match_w   (q_match_w),
    .match_imm (q_match_imm)
  );

  // A source whose destination still has a load in flight must wait (write-after-write).
  assign imm_elig = imm_valid && !q_match_imm;
  assign alu_elig = alu_valid && !q_match_w;

`ifdef RF_WB_RR_EN
  logic rr_alu_p1;

  always_comb begin
    imm_grant = 1'b0;
    alu_grant = 1'b0;
    if (!mem_win) begin
      if (imm_elig && alu_elig) begin
        alu_grant = rr_alu_p1;
        imm_grant = !rr_alu_p1;
      end else begin
        imm_grant = imm_elig;
        alu_grant = alu_elig;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)          rr_alu_p1 <= 1'b1;
    else if (imm_grant) rr_alu_p1 <= 1'b1;
    else if (alu_grant) rr_alu_p1 <= 1'b0;
  end
`else
  assign imm_grant = !mem_win && imm_elig;
  assign alu_grant = !mem_win && !imm_elig && alu_elig;
`endif

  assign imm_ready = imm_grant;
  assign alu_ready = alu_grant;

  // Stage p0: select the granted write.
  always_comb begin
    src_p0   = SRC_NONE;
    waddr_p0 = alu_waddr;
    wdata_p0 = alu_data;
    if (mem_win) begin
      src_p0   = SRC_MEM;
      waddr_p0 = ld_head;
      wdata_p0 = mem_rdata;
    end else if (imm_grant) begin
      src_p0   = SRC_IMM;
      waddr_p0 = A'(IMM_REG);
      wdata_p0 = imm_data;
    end else if (alu_grant) begin
      src_p0   = SRC_ALU;
    end
  end

  // Stage p1: registered write port; address/data hold when idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      src_p1   <= SRC_NONE;
      rf_waddr <= '0;
      rf_wdata <= '0;
      ld_err   <= 1'b0;
    end else begin
      src_p1 <= src_p0;
      if (src_p0 != SRC_NONE) begin
        rf_waddr <= waddr_p0;
        rf_wdata <= wdata_p0;
      end
      if (mem_rvalid && ld_empty) ld_err <= 1'b1;
    end
  end

  assign rf_we  = (src_p1 != SRC_NONE);
  assign hazard = q_match_a || q_match_b ||
                  (rf_we && (rf_waddr == rd_addr_a || rf_waddr == rd_addr_b));

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: expected writes are queued by the stimulus and
// checked by a monitor whenever the write port fires; control outputs checked inline.
module tb_rf_wb_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       alu_valid, imm_valid, ld_issue_valid, mem_rvalid;
  logic [3:0] alu_waddr, ld_waddr, rd_addr_a, rd_addr_b;
  logic [7:0] alu_data, imm_data, mem_rdata;
  logic       alu_ready, imm_ready, ld_issue_ready, hazard, rf_we, ld_err;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;

  int n_checks = 0;
  int n_fails  = 0;
  logic [11:0] exp_q [$];

  rf_wb_ctrl dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .alu_valid      (alu_valid),
    .alu_waddr      (alu_waddr),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .imm_valid      (imm_valid),
    .imm_data       (imm_data),
    .imm_ready      (imm_ready),
    .ld_issue_valid (ld_issue_valid),
    .ld_waddr       (ld_waddr),
    .ld_issue_ready (ld_issue_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .hazard         (hazard),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .ld_err         (ld_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: every write-port beat must match the oldest expected write.
  always @(negedge Clk) begin
    if (rf_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL wb_unexpected: got addr %0d data 0x%0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          n_fails++;
          $display("FAIL wb_beat: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                   rf_waddr, rf_wdata, e[11:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1;
    alu_valid = 0; imm_valid = 0; ld_issue_valid = 0; mem_rvalid = 0;
    alu_waddr = 0; ld_waddr = 0; rd_addr_a = 0; rd_addr_b = 0;
    alu_data = 0; imm_data = 0; mem_rdata = 0;
    cyc(); cyc();
    Reset = 1'b0;
    settle();
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_issue_ready", ld_issue_ready, 1);
    chk("rst_hazard", hazard, 0);

    // Reset with two loads pending
    ld_issue_valid = 1; ld_waddr = 1; cyc();
    ld_waddr = 2; cyc();
    ld_issue_valid = 0; rd_addr_a = 1; settle();
    chk("mid_hazard_pending", hazard, 1);
    Reset = 1; cyc(); Reset = 0; settle();
    chk("mid_rst_ready", ld_issue_ready, 1);
    chk("mid_rst_hazard", hazard, 0);
    chk("mid_rst_we", rf_we, 0);
    rd_addr_a = 0;

    // Immediate beats ALU
    imm_valid = 1; imm_data = 8'hA1; alu_valid = 1; alu_waddr = 5; alu_data = 8'hB2;
    settle();
    chk("prio_imm_ready", imm_ready, 1);
    chk("prio_alu_ready", alu_ready, 0);
    exp_q.push_back({4'd3, 8'hA1});
    cyc();
    imm_valid = 0;
    chk("prio_we1", rf_we, 1);
    chk("prio_waddr1", rf_waddr, 3);
    settle();
    chk("prio_alu_ready2", alu_ready, 1);
    exp_q.push_back({4'd5, 8'hB2});
    cyc();
    alu_valid = 0;
    chk("prio_waddr2", rf_waddr, 5);
    cyc();
    chk("prio_idle_we", rf_we, 0);
    chk("prio_hold_waddr", rf_waddr, 5);

    // Load hazard through queue and through the write port
    ld_issue_valid = 1; ld_waddr = 7; settle();
    chk("hz_issue_ready", ld_issue_ready, 1);
    cyc();
    ld_issue_valid = 0; rd_addr_a = 7; settle();
    chk("hz_pending", hazard, 1);
    mem_rvalid = 1; mem_rdata = 8'h5A;
    exp_q.push_back({4'd7, 8'h5A});
    cyc();
    mem_rvalid = 0; settle();
    chk("hz_waddr", rf_waddr, 7);
    chk("hz_wdata", rf_wdata, 8'h5A);
    chk("hz_writing", hazard, 1);
    cyc();
    chk("hz_clear", hazard, 0);
    rd_addr_a = 0;

    // Fill the queue, refuse while full even with a simultaneous return
    for (int i = 0; i < 4; i++) begin
      ld_issue_valid = 1; ld_waddr = 4'(8 + i); settle();
      chk("full_fill_ready", ld_issue_ready, 1);
      cyc();
    end
    ld_waddr = 12; alu_valid = 1; alu_waddr = 9; alu_data = 8'h99; settle();
    chk("full_refuse", ld_issue_ready, 0);
    chk("waw_alu_block", alu_ready, 0);
    cyc();
    alu_valid = 0; mem_rvalid = 1; mem_rdata = 8'h11; settle();
    chk("full_pop_no_credit", ld_issue_ready, 0);
    exp_q.push_back({4'd8, 8'h11});
    cyc();
    mem_rvalid = 0; settle();
    chk("full_after_pop", ld_issue_ready, 1);
    ld_issue_valid = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1; mem_rdata = 8'(8'h22 * (i + 1));
      exp_q.push_back({4'(9 + i), 8'(8'h22 * (i + 1))});
      cyc();
    end
    mem_rvalid = 0;

    // Immediate blocked by a pending load to r3
    ld_issue_valid = 1; ld_waddr = 3; cyc();
    ld_issue_valid = 0; imm_valid = 1; imm_data = 8'hC3; settle();
    chk("imm_blk_1", imm_ready, 0);
    cyc();
    chk("imm_blk_2", imm_ready, 0);
    mem_rvalid = 1; mem_rdata = 8'h77; settle();
    chk("imm_blk_ret", imm_ready, 0);
    exp_q.push_back({4'd3, 8'h77});
    cyc();
    mem_rvalid = 0; settle();
    chk("imm_unblk", imm_ready, 1);
    exp_q.push_back({4'd3, 8'hC3});
    cyc();
    imm_valid = 0;
    cyc();

    // Return with nothing pending
    chk("err_pre", ld_err, 0);
    mem_rvalid = 1; mem_rdata = 8'hEE; alu_valid = 1; alu_waddr = 2; alu_data = 8'hE2; settle();
    chk("err_alu_ready", alu_ready, 1);
    exp_q.push_back({4'd2, 8'hE2});
    cyc();
    mem_rvalid = 0; alu_valid = 0; settle();
    chk("err_set", ld_err, 1);
    chk("err_waddr", rf_waddr, 2);
    cyc();
    chk("err_sticky", ld_err, 1);
    chk("err_idle_we", rf_we, 0);

    cyc(); cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
